multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multicycle control unit for the RV32I subset: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal.
- Sequences each instruction through a Moore FSM.
- Produces datapath mux selects, write enables and the 3-bit alucontrol code consumed by the ALU.
- Consumes the ALU zero flag to resolve beq.

Parameters:
- RESET_STATE, FETCH, state entered on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- op  in  7  instr[6:0] from the instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU result-equals-zero flag.
- pcwrite  out  1  PC register enable.
- adrsrc  out  1  memory address select: 0 = PC, 1 = ALU/result.
- memwrite  out  1  data memory write enable.
- irwrite  out  1  instruction register and oldpc enable.
- regwrite  out  1  register file write enable.
- resultsrc  out  2  result mux: 00 = aluout reg, 01 = data reg, 10 = aluresult.
- alusrca  out  2  ALU A select: 00 = PC, 01 = oldpc, 10 = rs1 data.
- alusrcb  out  2  ALU B select: 00 = rs2 data, 01 = imm, 10 = constant 4.
- immsrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- alucontrol  out  3  ADD 000, SUB 001, AND 010, OR 011, SLT 101.
- illegal_op  out  1  high while in the ILLEGAL state.

Behaviour:
Clock and reset:
- One clock. Reset is synchronous and active-low: rst_n sampled low forces state <= FETCH.
- While rst_n is low, pcwrite/irwrite/memwrite/regwrite are gated to 0. All other outputs show the FETCH decode.

Output decode:
- All outputs are decoded from state only, except two:
  - pcwrite = pcupdate | (branch & zero).
  - immsrc is decoded from op combinationally: lw/I-type -> 00, sw -> 01, beq -> 10, jal -> 11, others -> 00.
- Any signal not listed for a state is 0.

States, outputs, next state:
- FETCH: adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, aluop=00, resultsrc=10, pcupdate=1 -> DECODE.
- DECODE: alusrca=01, alusrcb=01, aluop=00. Next state by op:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECUTER.
  - 0010011 -> EXECUTEI.
  - 1100011 -> BEQ.
  - 1101111 -> JAL.
  - Any other op, or an unsupported funct3 for R/I/branch/load/store -> ILLEGAL.
- MEMADR: alusrca=10, alusrcb=01, aluop=00 -> MEMREAD if op=lw, else MEMWRITE.
- MEMREAD: adrsrc=1, resultsrc=00 -> MEMWB.
- MEMWB: resultsrc=01, regwrite=1 -> FETCH.
- MEMWRITE: adrsrc=1, resultsrc=00, memwrite=1 -> FETCH.
- EXECUTER: alusrca=10, alusrcb=00, aluop=10 -> ALUWB.
- EXECUTEI: alusrca=10, alusrcb=01, aluop=10 -> ALUWB.
- ALUWB: resultsrc=00, regwrite=1 -> FETCH.
- BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1 -> FETCH.
- JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1 -> ALUWB.
- ILLEGAL: all enables 0, illegal_op=1. Sticky until reset.

ALU decode (aluop -> alucontrol):
- aluop 00 -> ADD. aluop 01 -> SUB.
- aluop 10, by funct3:
  - 000 -> SUB if (op[5] & funct7b5), else ADD. So addi with imm[10]=1 stays ADD.
  - 010 -> SLT. 110 -> OR. 111 -> AND.
  - Any other funct3 is unreachable, because DECODE traps it.
- aluop 11 -> ADD (unused).

Latency in cycles, FETCH inclusive: lw 5, sw 4, R 4, I 4, beq 3, jal 4.

Boundary conditions:
- Reset mid-instruction: the next cycle is FETCH with no write enable asserted during the reset cycle. A partially executed sw/lw/ALU writeback never commits.
- beq: the zero flag is sampled combinationally in the BEQ cycle only. If zero is 0, pcwrite stays 0 and PC keeps PC+4 from FETCH.
- Simultaneous reset and ILLEGAL: reset wins.

Decomposition:
- Package sprv32_ctrl_pkg holds:
  - state enum;
  - alucontrol codes (ADD/SUB/AND/OR/SLT);
  - opcode constants;
  - resultsrc/alusrca/alusrcb/immsrc select encodings.
- One sub-module: alu_decoder (aluop, funct3, funct7b5, op5 -> alucontrol), purely combinational.
- The FSM stays in multicycle_ctrl.

Test Plan:
- lw (op=0000011, f3=010) from reset: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. irwrite=1 only in cycle 1, regwrite=1 only in cycle 5, resultsrc=01 in cycle 5. Back to FETCH in cycle 6.
- R-type sub (op=0110011, f3=000, f7b5=1): EXECUTER shows alucontrol=001, alusrcb=00. ALUWB regwrite=1. Same with f7b5=0 gives 000. addi with funct7b5=1 gives 000.
- beq with zero=1 in BEQ: pcwrite=1, alucontrol=001. Repeat with zero=0: pcwrite=0. Both return to FETCH after 3 cycles.
- jal (op=1101111): JAL cycle pcwrite=1, alusrca=01, alusrcb=10, immsrc=11. Then ALUWB regwrite=1.
- Illegal op 0000000, then R-type with f3=001: both enter ILLEGAL after DECODE. illegal_op=1 held 10 cycles with all enables 0. rst_n low for 1 cycle -> FETCH, illegal_op=0.
- sw with rst_n pulsed low in the MEMADR cycle: memwrite never asserts. FETCH follows with irwrite=1 once rst_n is high.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle control unit:
// FSM states, ALU codes, opcodes and datapath select encodings.
package sprv32_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, ILLEGAL
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Only the funct3 values the datapath implements are accepted; jal has none.
  function automatic logic funct3_legal(input logic [6:0] op, input logic [2:0] funct3);
    case (op)
      OP_LOAD, OP_STORE: return funct3 == 3'b010;
      OP_RTYPE, OP_ITYPE: return funct3 inside {3'b000, 3'b010, 3'b110, 3'b111};
      OP_BRANCH:         return funct3 == 3'b000;
      OP_JAL:            return 1'b1;
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pcwrite;
  logic       adrsrc;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic [1:0] resultsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] immsrc;
  logic [2:0] alucontrol;
  logic       illegal_op;

  modport master (
    input  op, funct3, funct7b5, zero,
    output pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
           alusrca, alusrcb, immsrc, alucontrol, illegal_op
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
           alusrca, alusrcb, immsrc, alucontrol, illegal_op
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's aluop plus instruction fields to alucontrol.
module alu_decoder
  import sprv32_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type from addi, whose imm[10] aliases funct7b5
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-FSM control unit for a multicycle RV32I subset (lw/sw/R/I/beq/jal).
module multicycle_ctrl
  import sprv32_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = FETCH
) (
  input logic               clk,
  input logic               rst_n,
  multicycle_ctrl_if.master bus
);

  state_t state_q, state_d, dec_state;
  aluop_t aluop;
  logic   pcupdate, branch, irwrite_s, regwrite_s, memwrite_s;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        if (!funct3_legal(bus.op, bus.funct3)) state_d = ILLEGAL;
        else begin
          case (bus.op)
            OP_LOAD, OP_STORE: state_d = MEMADR;
            OP_RTYPE:          state_d = EXECUTER;
            OP_ITYPE:          state_d = EXECUTEI;
            OP_BRANCH:         state_d = BEQ;
            OP_JAL:            state_d = JAL;
            default:           state_d = ILLEGAL;
          endcase
        end
      end
      MEMADR:   state_d = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = FETCH;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      JAL:      state_d = ALUWB;
      ILLEGAL:  state_d = ILLEGAL;
      default:  state_d = FETCH;
    endcase
  end

  // During reset the outputs show the reset-state decode; enables are gated below.
  assign dec_state = rst_n ? state_q : RESET_STATE;

  always_comb begin
    pcupdate       = 1'b0;
    branch         = 1'b0;
    irwrite_s      = 1'b0;
    regwrite_s     = 1'b0;
    memwrite_s     = 1'b0;
    bus.adrsrc     = 1'b0;
    bus.resultsrc  = RES_ALUOUT;
    bus.alusrca    = SRCA_PC;
    bus.alusrcb    = SRCB_RS2;
    bus.illegal_op = 1'b0;
    aluop          = ALUOP_ADD;
    case (dec_state)
      FETCH: begin
        irwrite_s = 1'b1; pcupdate = 1'b1;
        bus.alusrcb = SRCB_FOUR; bus.resultsrc = RES_ALURESULT;
      end
      DECODE:   begin bus.alusrca = SRCA_OLDPC; bus.alusrcb = SRCB_IMM; end
      MEMADR:   begin bus.alusrca = SRCA_RS1; bus.alusrcb = SRCB_IMM; end
      MEMREAD:  bus.adrsrc = 1'b1;
      MEMWB:    begin bus.resultsrc = RES_DATA; regwrite_s = 1'b1; end
      MEMWRITE: begin bus.adrsrc = 1'b1; memwrite_s = 1'b1; end
      EXECUTER: begin bus.alusrca = SRCA_RS1; aluop = ALUOP_FUNCT; end
      EXECUTEI: begin bus.alusrca = SRCA_RS1; bus.alusrcb = SRCB_IMM; aluop = ALUOP_FUNCT; end
      ALUWB:    regwrite_s = 1'b1;
      BEQ:      begin bus.alusrca = SRCA_RS1; aluop = ALUOP_SUB; branch = 1'b1; end
      JAL: begin
        bus.alusrca = SRCA_OLDPC; bus.alusrcb = SRCB_FOUR; pcupdate = 1'b1;
      end
      ILLEGAL:  bus.illegal_op = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_STORE:  bus.immsrc = IMM_S;
      OP_BRANCH: bus.immsrc = IMM_B;
      OP_JAL:    bus.immsrc = IMM_J;
      default:   bus.immsrc = IMM_I;
    endcase
  end

  assign bus.pcwrite  = rst_n & (pcupdate | (branch & bus.zero));
  assign bus.irwrite  = rst_n & irwrite_s;
  assign bus.regwrite = rst_n & regwrite_s;
  assign bus.memwrite = rst_n & memwrite_s;

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (bus.funct3),
    .funct7b5   (bus.funct7b5),
    .op5        (bus.op[5]),
    .alucontrol (bus.alucontrol)
  );

endmodule
